// File: rtl/mixer_pkg.sv
// Shared widths, sample/carrier/product types and saturation limits for the
// ring-modulator mixer.
package mixer_pkg;

   localparam int SAMPLE_W    = 16;
   localparam int CAR_W       = 12;
   localparam int ROUND_SHIFT = CAR_W - 1;
   localparam int PROD_W      = SAMPLE_W + CAR_W;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic        [CAR_W-1:0]    carrier_t;
   typedef logic signed [PROD_W-1:0]   product_t;

   localparam sample_t SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam sample_t SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

   // The DDS carrier is offset-binary; flipping the MSB gives two's complement.
   function automatic logic signed [CAR_W-1:0] car_to_signed(input carrier_t car);
      return {~car[CAR_W-1], car[CAR_W-2:0]};
   endfunction

endpackage

// File: rtl/carrier_mixer_round_sat.sv
// Combinational round-half-up, arithmetic shift and clamp of a full-width
// product back to audio width; sat flags a clamped result.
module round_sat
   import mixer_pkg::*;
(
   input  product_t prod,
   output sample_t  result,
   output logic     sat
);

   localparam int SUM_W = PROD_W + 1;
   localparam int R_W   = SUM_W - ROUND_SHIFT;
   localparam logic signed [R_W-1:0] R_MAX = R_W'(SAT_MAX);
   localparam logic signed [R_W-1:0] R_MIN = R_W'(SAT_MIN);

   logic signed [SUM_W-1:0] sum;
   logic signed [R_W-1:0]   r;

   // One guard bit keeps the rounding add from wrapping before the shift.
   always_comb begin
      sum    = {prod[PROD_W-1], prod} + SUM_W'(2 ** (ROUND_SHIFT - 1));
      r      = sum[SUM_W-1:ROUND_SHIFT];
      sat    = 1'b0;
      result = r[SAMPLE_W-1:0];
      if (r > R_MAX) begin
         sat    = 1'b1;
         result = SAT_MAX;
      end else if (r < R_MIN) begin
         sat    = 1'b1;
         result = SAT_MIN;
      end
   end

endmodule

// File: rtl/carrier_mixer.sv
// Three-stage ring modulator: capture sample+carrier, multiply, then
// round/saturate into the output register. Counts saturated outputs.
module carrier_mixer
   import mixer_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CAR_W-1:0]    car_in,
   input  logic [SAMPLE_W-1:0] in_data,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                bypass,
   output logic [SAMPLE_W-1:0] out_data,
   output logic                out_valid,
   input  logic                out_ready,
   input  logic                sat_clr,
   output logic [CNT_W-1:0]    sat_count
);

   // Handshake: a beat transfers on any edge where valid and ready are both 1;
   // a producer holds valid/data until that edge. The whole pipe advances
   // together whenever the output register is empty or being drained.
   logic     adv;
   logic     accept;
   logic     s1_valid, s1_bypass;
   sample_t  s1_sample;
   carrier_t s1_car;
   logic     s2_valid, s2_bypass;
   sample_t  s2_sample;
   product_t s2_prod;
   sample_t  rs_result;
   logic     rs_sat;
   logic     sat_event;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign accept   = in_valid && adv;

   round_sat u_round_sat (
      .prod   (s2_prod),
      .result (rs_result),
      .sat    (rs_sat)
   );

   // Bubbles and bypassed samples never count, whatever stale data they carry.
   assign sat_event = adv && s2_valid && !s2_bypass && rs_sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_bypass <= 1'b0;
         s1_sample <= '0;
         s1_car    <= '0;
         s2_valid  <= 1'b0;
         s2_bypass <= 1'b0;
         s2_sample <= '0;
         s2_prod   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (adv) begin
         s1_valid  <= accept;
         s1_bypass <= bypass;
         s1_sample <= sample_t'(in_data);
         s1_car    <= car_in;
         s2_valid  <= s1_valid;
         s2_bypass <= s1_bypass;
         s2_sample <= s1_sample;
         s2_prod   <= product_t'(s1_sample) * product_t'(car_to_signed(s1_car));
         out_valid <= s2_valid;
         out_data  <= s2_bypass ? s2_sample : rs_result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count <= '0;
      end else if (sat_clr) begin
         sat_count <= '0;
      end else if (sat_event && (sat_count != '1)) begin
         sat_count <= sat_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_carrier_mixer.sv
// Directed bench for carrier_mixer: arithmetic reference model, per-beat
// output compare and literal checks for scaling, saturation, bypass and reset.
module tb_carrier_mixer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] car_in;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        bypass;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        sat_clr;
   logic [15:0] sat_count;

   int          total = 0;
   int          bad   = 0;
   int          out_cnt = 0;
   logic [15:0] last_out = '0;
   logic [15:0] exp_sat  = '0;
   logic [15:0] exp_q[$];

   carrier_mixer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .car_in    (car_in),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bypass    (bypass),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sat_clr   (sat_clr),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: signed product with the centred carrier, round half up to
   // the nearest multiple of 2048, then clamp to 16-bit signed.
   function automatic logic [15:0] model(input int s, input int car, input bit byp,
                                         output bit sat);
      longint p;
      longint r;
      sat = 1'b0;
      if (byp) return 16'(s);
      p = longint'(s) * longint'(car - 2048);
      r = (p + 1024) >>> 11;
      if (r > 32767) begin
         sat = 1'b1;
         return 16'h7FFF;
      end
      if (r < -32768) begin
         sat = 1'b1;
         return 16'h8000;
      end
      return 16'(r);
   endfunction

   // Output scoreboard: every transferred beat must match the queue head.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(out_data), 32'hDEAD_BEEF);
         end else begin
            check("out_data", 32'(out_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
         end
         last_out = out_data;
         out_cnt++;
      end
   end

   task automatic send(input int s, input int car, input bit byp);
      bit          sat;
      logic [15:0] e;
      int          n;
      in_data  = 16'(s);
      car_in   = 12'(car);
      bypass   = byp;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", 32'(in_ready), 32'd1);
      end else begin
         e = model(s, car, byp, sat);
         exp_q.push_back(e);
         if (sat && !byp && exp_sat != 16'hFFFF) exp_sat++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic measure_latency(input string name);
      int lat;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check(name, 32'(lat), 32'd3);
   endtask

   task automatic stall_window();
      repeat (4) @(posedge clk);
      #1;
      out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_out_data", 32'(out_data), 32'(exp_q[0]));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
   endtask

   task automatic stream_ten();
      for (int i = 1; i <= 10; i++) send(i, 12'hFFF, 1'b0);
   endtask

   initial begin
      bit dummy;
      int base_cnt;
      rst_n     = 1'b0;
      car_in    = 12'h800;
      in_data   = '0;
      in_valid  = 1'b0;
      bypass    = 1'b0;
      out_ready = 1'b1;
      sat_clr   = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_sat_count", 32'(sat_count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Pin the model to hand-computed values
      check("model_scale", 32'(model(16384, 12'hFFF, 1'b0, dummy)), 32'd16376);
      check("model_zero", 32'(model(-12345, 12'h800, 1'b0, dummy)), 32'd0);
      check("model_sat", 32'(model(-32768, 12'h000, 1'b0, dummy)), 32'h7FFF);
      check("model_neg", 32'(model(32767, 12'h000, 1'b0, dummy)), 32'h8001);

      // Scaling and latency
      send(16384, 12'hFFF, 1'b0);
      measure_latency("latency");
      drain();
      check("scale_out", 32'(last_out), 32'd16376);
      check("scale_sat", 32'(sat_count), 32'd0);

      // Zero carrier
      send(-12345, 12'h800, 1'b0);
      drain();
      check("zero_out", 32'(last_out), 32'd0);

      // Saturation, then idle bubbles carrying saturating stale data
      send(-32768, 12'h000, 1'b0);
      drain();
      check("sat_out", 32'(last_out), 32'h7FFF);
      check("sat_count1", 32'(sat_count), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      check("bubble_sat", 32'(sat_count), 32'(exp_sat));
      send(32767, 12'h000, 1'b0);
      drain();
      check("neg_out", 32'(last_out), 32'h8001);
      check("neg_sat", 32'(sat_count), 32'd1);

      // Clear coinciding with a saturation event: clear wins
      send(-32768, 12'h000, 1'b0);
      @(posedge clk);
      #1;
      sat_clr = 1'b1;
      @(posedge clk);
      #1;
      sat_clr = 1'b0;
      exp_sat = '0;
      drain();
      check("clr_out", 32'(last_out), 32'h7FFF);
      check("clr_sat", 32'(sat_count), 32'd0);

      // Back-to-back stream with a 5-cycle output stall
      base_cnt = out_cnt;
      fork
         stream_ten();
         stall_window();
      join
      drain();
      check("stream_count", 32'(out_cnt - base_cnt), 32'd10);
      check("stream_last", 32'(last_out), 32'd10);

      // Bypass passes verbatim, no saturation counting
      send(-32768, 12'h000, 1'b1);
      drain();
      check("byp_out", 32'(last_out), 32'h8000);
      check("byp_sat", 32'(sat_count), 32'(exp_sat));
      send(1234, 12'hFFF, 1'b1);
      drain();
      check("byp_out2", 32'(last_out), 32'd1234);

      // Carrier is taken at acceptance
      send(1000, 12'h000, 1'b0);
      car_in = 12'hFFF;
      drain();
      check("car_capture", 32'(last_out), 32'hFC18);

      // Reset with two samples in flight
      send(-32768, 12'h000, 1'b0);
      drain();
      check("pre_rst_sat", 32'(sat_count), 32'd1);
      send(-32768, 12'h000, 1'b0);
      send(222, 12'hFFF, 1'b0);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      exp_sat = '0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_sat", 32'(sat_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_idle", 32'(out_valid), 32'd0);
      send(16384, 12'hFFF, 1'b0);
      measure_latency("post_rst_latency");
      drain();
      check("post_rst_out", 32'(last_out), 32'd16376);
      check("post_rst_sat", 32'(sat_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
